// File: rtl/lstm_seq_ctrl_if.sv
// Bundle of the start/status, sample stream, cell drive and hidden-state stream
// signals shared between the LSTM sequence controller and its environment.
interface lstm_seq_ctrl_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  start;
  logic [DATA_WIDTH-1:0] x_in;
  logic                  x_valid;
  logic                  x_ready;
  logic [DATA_WIDTH-1:0] cell_x;
  logic [DATA_WIDTH-1:0] cell_c_in;
  logic [DATA_WIDTH-1:0] cell_h_in;
  logic [DATA_WIDTH-1:0] cell_c_out;
  logic [DATA_WIDTH-1:0] cell_h_out;
  logic [DATA_WIDTH-1:0] h_out;
  logic                  h_valid;
  logic                  h_last;
  logic                  h_ready;
  logic                  busy;
  logic                  done;

  modport slave (
    input  start, x_in, x_valid, cell_c_out, cell_h_out, h_ready,
    output x_ready, cell_x, cell_c_in, cell_h_in, h_out, h_valid, h_last, busy, done
  );

  modport master (
    output start, x_in, x_valid, cell_c_out, cell_h_out, h_ready,
    input  x_ready, cell_x, cell_c_in, cell_h_in, h_out, h_valid, h_last, busy, done
  );
endinterface

// File: rtl/lstm_seq_ctrl.sv
// Sequences one LSTM cell over SEQ_LEN time steps: takes a sample, lets the cell
// settle for CELL_LAT cycles, captures c/h and emits h with ready/valid backpressure.
module lstm_seq_ctrl #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRACT_WIDTH = 8,
  parameter int SEQ_LEN     = 8,
  parameter int CELL_LAT    = 1
) (
  input logic           clk,
  input logic           rst,
  lstm_seq_ctrl_if.slave bus
);

  localparam int SW = $clog2(SEQ_LEN) + 1;
  localparam int EW = (CELL_LAT > 1) ? $clog2(CELL_LAT) : 1;
  localparam logic [SW-1:0] LAST_STEP = SW'(SEQ_LEN - 1);
  localparam logic [EW-1:0] EVAL_LAST = EW'(CELL_LAT - 1);

  // Fixed-point format is only carried through; reject nonsensical configurations.
  if (FRACT_WIDTH > DATA_WIDTH) begin : g_fract_chk
    $error("FRACT_WIDTH exceeds DATA_WIDTH");
  end
  if (SEQ_LEN < 1 || CELL_LAT < 1) begin : g_len_chk
    $error("SEQ_LEN and CELL_LAT must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_X = 2'd1,
    EVAL   = 2'd2,
    EMIT   = 2'd3
  } state_t;

  state_t                state_r;
  logic [DATA_WIDTH-1:0] x_r;
  logic [DATA_WIDTH-1:0] c_r;
  logic [DATA_WIDTH-1:0] h_r;
  logic [SW-1:0]         step_r;
  logic [EW-1:0]         eval_cnt_r;
  logic                  x_ready_r;
  logic                  h_valid_r;
  logic                  h_last_r;
  logic                  busy_r;
  logic                  done_r;

  // Sequencing FSM; status flags are set alongside the transition that enters their state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      x_r        <= '0;
      c_r        <= '0;
      h_r        <= '0;
      step_r     <= '0;
      eval_cnt_r <= '0;
      x_ready_r  <= 1'b0;
      h_valid_r  <= 1'b0;
      h_last_r   <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            c_r       <= '0;
            h_r       <= '0;
            step_r    <= '0;
            x_ready_r <= 1'b1;
            busy_r    <= 1'b1;
            state_r   <= WAIT_X;
          end
        end
        WAIT_X: begin
          if (bus.x_valid) begin
            x_r        <= bus.x_in;
            eval_cnt_r <= '0;
            x_ready_r  <= 1'b0;
            state_r    <= EVAL;
          end
        end
        EVAL: begin
          if (eval_cnt_r == EVAL_LAST) begin
            c_r       <= bus.cell_c_out;
            h_r       <= bus.cell_h_out;
            h_valid_r <= 1'b1;
            h_last_r  <= (step_r == LAST_STEP);
            state_r   <= EMIT;
          end else begin
            eval_cnt_r <= eval_cnt_r + EW'(1);
          end
        end
        EMIT: begin
          if (bus.h_ready) begin
            h_valid_r <= 1'b0;
            h_last_r  <= 1'b0;
            if (step_r == LAST_STEP) begin
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= IDLE;
            end else begin
              step_r    <= step_r + SW'(1);
              x_ready_r <= 1'b1;
              state_r   <= WAIT_X;
            end
          end
        end
        default: begin
          x_ready_r <= 1'b0;
          h_valid_r <= 1'b0;
          h_last_r  <= 1'b0;
          busy_r    <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  assign bus.cell_x    = x_r;
  assign bus.cell_c_in = c_r;
  assign bus.cell_h_in = h_r;
  assign bus.h_out     = h_r;
  assign bus.x_ready   = x_ready_r;
  assign bus.h_valid   = h_valid_r;
  assign bus.h_last    = h_last_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

endmodule

// File: doc/lstm_seq_ctrl.md
LSTM_SEQ_CTRL -- requirements
Module: lstm_seq_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DATA_WIDTH, 16, word width of all data ports.
- FRACT_WIDTH, 8, fractional bits (Q8.8); carried through unchanged, no arithmetic here.
- SEQ_LEN, 8, time steps per sequence, >=1.
- CELL_LAT, 1, cycles allowed for the cell to settle before capture, >=1.
REQ-002 Ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  sole clock; everything samples on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- start  in  1  begin new sequence; honoured only in IDLE.
- x_in  in  DATA_WIDTH  input sample X.
- x_valid  in  1  x_in valid.
- x_ready  out  1  block accepts x_in this cycle.
- cell_x  out  DATA_WIDTH  X presented to the cell.
- cell_c_in  out  DATA_WIDTH  previous cell state presented to the cell.
- cell_h_in  out  DATA_WIDTH  previous hidden state presented to the cell.
- cell_c_out  in  DATA_WIDTH  cell's new cell state.
- cell_h_out  in  DATA_WIDTH  cell's new hidden state.
- h_out  out  DATA_WIDTH  hidden state for the current step.
- h_valid  out  1  h_out valid.
- h_last  out  1  h_out belongs to the final step.
- h_ready  in  1  downstream accepts h_out.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when the sequence completes.

Function
REQ-003 FSM states: IDLE, WAIT_X, EVAL, EMIT; all transitions on the rising edge of clk.
REQ-004 IDLE, start=1: c_reg, h_reg, step cleared to 0; next state WAIT_X. IDLE, start=0: hold.
REQ-005 start is ignored in every state other than IDLE.
REQ-006 x_ready = 1 only in WAIT_X.
REQ-007 WAIT_X, x_valid=1: x_reg <= x_in, eval counter <= 0, next state EVAL. WAIT_X, x_valid=0: hold, no register change.
REQ-008 Cell drive, at all times: cell_x = x_reg, cell_c_in = c_reg, cell_h_in = h_reg.
REQ-009 EVAL lasts exactly CELL_LAT cycles. On the edge where the eval counter equals CELL_LAT-1: c_reg <= cell_c_out, h_reg <= cell_h_out, next state EMIT.
REQ-010 Output valid: h_valid = 1 only in EMIT. h_out = h_reg continuously.
REQ-011 h_last = 1 only in EMIT and only when step == SEQ_LEN-1.
REQ-012 EMIT, h_ready=0: hold; h_out, h_last, c_reg, h_reg stable.
REQ-013 EMIT, h_ready=1:
- step < SEQ_LEN-1: step++, next state WAIT_X.
- step == SEQ_LEN-1: next state IDLE, done=1 for exactly that next cycle.
REQ-014 Step counter width is clog2(SEQ_LEN)+1 bits; it never wraps within a sequence.
REQ-015 Latency from the x handshake edge to h_valid rising is CELL_LAT+1 cycles.
REQ-016 c_reg and h_reg persist across steps within a sequence; they are cleared only by start or by reset.
REQ-017 x_valid while x_ready=0 has no effect; a sample is never consumed twice.

Reset
REQ-018 rst=0 asynchronously forces:
- state IDLE;
- x_reg, c_reg, h_reg, step, eval counter = 0;
- x_ready, h_valid, h_last, busy, done = 0;
- cell_x, cell_c_in, cell_h_in, h_out = 0.
REQ-019 Reset mid-sequence, in any state, abandons the sequence; no done pulse is issued.
REQ-020 After rst deasserts, the block stays in IDLE until start=1.

Verification
Cell stub used by all scenarios: cell_c_out = cell_c_in + cell_x; cell_h_out = cell_x.
REQ-021 Basic sequence: SEQ_LEN=3, start, x = 0x0100, 0x0200, 0x0080, h_ready=1 -> h_out = 0x0100, 0x0200, 0x0080; c_reg = 0x0100, 0x0300, 0x0380; h_last only on the third; done one cycle after the third handshake.
REQ-022 Latency: CELL_LAT=3, x handshake at cycle T -> h_valid first high at T+4.
REQ-023 Backpressure: h_ready=0 for 5 cycles in EMIT -> h_valid, h_out stable; x_ready=0 throughout; completes on h_ready=1.
REQ-024 Idle input: x_valid=0 for 4 cycles in WAIT_X -> state, step, and registers unchanged; a gap before the second sample leaves its output unaffected.
REQ-025 Ignored start: start=1 in EVAL -> ignored; c_reg not cleared. A second start after done -> c_reg restarts from 0.
REQ-026 Mid-sequence reset: rst=0 in EMIT at step 1 -> all outputs 0 immediately, no done pulse. The next start plus x = 0x0100 -> c_reg = 0x0100.
